// File: rtl/ram_sqrt_seed_pkg.sv
// Shared constants, sequencer state type and the elaboration-time sqrt seed table.
// Each seed is the midpoint of two adjacent square roots, rounded and shifted up 8 bits.
package ram_sqrt_seed_pkg;

  localparam int DEPTH  = 1024;
  localparam int WIDTH  = 24;
  localparam int ADDR_W = 10;

  typedef enum logic {
    RESTORE = 1'b0,
    IDLE    = 1'b1
  } state_e;

  typedef logic [DEPTH-1:0][WIDTH-1:0] seed_table_t;

  // Exact test of c <= sqrt(sa) + sqrt(sb) using only integer arithmetic.
  function automatic logic root_sum_ge(input logic [127:0] c,
                                       input logic [127:0] sa,
                                       input logic [127:0] sb);
    logic [127:0] c2;
    logic [127:0] d;
    logic         res;
    c2 = c * c;
    if (c2 <= sa + sb) begin
      res = 1'b1;
    end else begin
      d   = c2 - sa - sb;
      res = ((d * d) <= ((sa * sb) << 2));
    end
    return res;
  endfunction

  // R(i) is the largest n with 2n-1 <= sqrt(A)+sqrt(B); R never decreases with i,
  // so each entry resumes the search from the previous result.
  function automatic seed_table_t build_seed_table();
    seed_table_t  t;
    logic [127:0] r;
    logic [127:0] sa;
    logic [127:0] sb;
    int           idx;
    t = '0;
    r = 128'd32768;
    for (int hi = 0; hi < 32; hi++) begin
      for (int lo = 0; lo < 32; lo++) begin
        idx = hi * 32 + lo;
        sa  = 128'(1024 + idx) << 20;
        sb  = 128'(1025 + idx) << 20;
        while (root_sum_ge((r << 1) + 128'd1, sa, sb)) begin
          r = r + 128'd1;
        end
        t[idx] = WIDTH'(r << 8);
      end
    end
    return t;
  endfunction

  localparam seed_table_t SEED_TABLE = build_seed_table();

endpackage

// File: rtl/ram_sqrt_seed_rom.sv
// Constant 10-bit to 24-bit lookup of the sqrt seed table.
module sqrt_seed_rom
  import ram_sqrt_seed_pkg::*;
(
  input  logic [ADDR_W-1:0] addr,
  output logic [WIDTH-1:0]  data
);

  assign data = SEED_TABLE[addr];

endmodule

// File: rtl/ram_sqrt_seed.sv
// Single-port 1024x24 RAM preloaded with sqrt seeds; after each reset a sequencer
// rewrites every word from the seed ROM before user writes are accepted.
module ram_sqrt_seed
  import ram_sqrt_seed_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  in_a,
  output logic [WIDTH-1:0]  a,
  output logic              ready
);

  // No reset on the array: contents survive reset and start out as the seed table.
  logic [DEPTH-1:0][WIDTH-1:0] mem = SEED_TABLE;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] k_q, k_d;
  logic              ready_q, ready_d;
  logic [WIDTH-1:0]  a_q, a_d;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic [WIDTH-1:0]  rom_data;

  sqrt_seed_rom u_rom (
    .addr (k_q),
    .data (rom_data)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    ready_d = ready_q;
    a_d     = mem[addr];
    wr_en   = 1'b0;
    wr_addr = addr;
    wr_data = in_a;
    case (state_q)
      RESTORE: begin
        wr_en   = !rst;
        wr_addr = k_q;
        wr_data = rom_data;
        ready_d = 1'b0;
        // The counter holds at the last word instead of wrapping.
        if (k_q == ADDR_W'(DEPTH - 1)) begin
          state_d = IDLE;
          ready_d = 1'b1;
        end else begin
          k_d = k_q + ADDR_W'(1);
        end
      end
      IDLE: begin
        wr_en   = load && !rst;
        ready_d = 1'b1;
      end
      default: begin
        state_d = RESTORE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RESTORE;
      k_q     <= '0;
      ready_q <= 1'b0;
      a_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      ready_q <= ready_d;
      a_q     <= a_d;
    end
  end

  // Read-before-write: a_q captures the old word on the same edge as the write.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign a     = a_q;
  assign ready = ready_q;

endmodule

// File: tb/tb_ram_sqrt_seed.sv
// Randomized scoreboard bench for ram_sqrt_seed against a real-arithmetic seed model.
module tb_ram_sqrt_seed;

  localparam int DEPTH = 1024;

  logic        clk  = 1'b0;
  logic        rst  = 1'b0;
  logic        load = 1'b0;
  logic [9:0]  addr = '0;
  logic [23:0] in_a = '0;
  logic [23:0] a;
  logic        ready;

  int checks   = 0;
  int failures = 0;
  int cyc_cnt  = 0;

  logic [23:0] exp_q[$];
  int          cyc_q[$];
  string       name_q[$];

  logic [23:0] seed_ref[DEPTH];
  logic [23:0] ref_mem[DEPTH];

  logic [23:0] mon_exp;
  int          mon_cyc;
  string       mon_name;

  ram_sqrt_seed dut (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .addr  (addr),
    .in_a  (in_a),
    .a     (a),
    .ready (ready)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // ---------------- reference model ----------------
  function automatic logic [23:0] s_model(input int i);
    real lo_r;
    real hi_r;
    int  r;
    lo_r = $sqrt(real'(1024 + i) * 1048576.0);
    hi_r = $sqrt(real'(1025 + i) * 1048576.0);
    r    = $rtoi((lo_r + hi_r) / 2.0 + 0.5);
    return 24'(r << 8);
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    while (cyc_q.size() > 0 && cyc_q[0] <= cyc_cnt) begin
      mon_exp  = exp_q.pop_front();
      mon_cyc  = cyc_q.pop_front();
      mon_name = name_q.pop_front();
      checks++;
      if (a !== mon_exp) begin
        failures++;
        $display("FAIL %s: a=%h expected %h (cycle %0d)", mon_name, a, mon_exp, mon_cyc);
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic step(input logic ld, input logic [9:0] ad, input logic [23:0] dat,
                      input logic [23:0] ex, input bit chk, input string nm);
    load = ld;
    addr = ad;
    in_a = dat;
    if (chk) begin
      exp_q.push_back(ex);
      cyc_q.push_back(cyc_cnt + 1);
      name_q.push_back(nm);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_op(input logic ld, input logic [9:0] ad, input logic [23:0] dat,
                         input string nm);
    step(ld, ad, dat, ref_mem[ad], 1'b1, nm);
    if (ld) ref_mem[ad] = dat;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_async_a", 32'(a), 32'h0);
    check("rst_async_ready", 32'(ready), 32'h0);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 10'($urandom_range(0, DEPTH - 1)), 24'($urandom), 24'h0, 1'b1, "rst_a");
      check("rst_ready", 32'(ready), 32'h0);
    end
    rst = 1'b0;
  endtask

  // Word i holds its seed once restore edge i+1 has passed; later words keep old data.
  task automatic run_restore(input int max_edges, output int rise);
    logic [9:0]  ad;
    logic [23:0] dat;
    logic [23:0] ex;
    logic        ld;
    int          done;
    rise = 0;
    done = 0;
    for (int e = 1; e <= max_edges; e++) begin
      ad  = 10'($urandom_range(0, DEPTH - 1));
      dat = 24'($urandom);
      ld  = ($urandom_range(0, 3) == 0);
      if (e == 100) begin
        ld  = 1'b1;
        ad  = 10'd900;
        dat = 24'h123456;
      end
      ex = (int'(ad) <= e - 2) ? seed_ref[ad] : ref_mem[ad];
      step(ld, ad, dat, ex, 1'b1, "restore_rd");
      done = e;
      if (ready === 1'b1) begin
        rise = e;
        break;
      end
    end
    if (done > DEPTH) done = DEPTH;
    for (int i = 0; i < done; i++) ref_mem[i] = seed_ref[i];
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          rise;
    logic [9:0]  ad;
    for (int i = 0; i < DEPTH; i++) begin
      seed_ref[i] = s_model(i);
      ref_mem[i]  = seed_ref[i];
    end

    // Power-up contents, no reset applied.
    step(1'b0, 10'd0,    24'h0, 24'h800800, 1'b1, "pwrup_addr0");
    step(1'b0, 10'd1023, 24'h0, 24'hB4FF00, 1'b1, "pwrup_addr1023");
    for (int i = 0; i < 8; i++) begin
      ad = 10'($urandom_range(0, DEPTH - 1));
      step(1'b0, ad, 24'h0, seed_ref[ad], 1'b1, "pwrup_rand");
    end

    // Full restore, ignored write to 900 mid-restore, then sweep.
    do_reset(3);
    run_restore(1100, rise);
    check("ready_rise_cycle", 32'(rise), 32'd1024);
    check("ready_high", 32'(ready), 32'h1);
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 10'(i), 24'h0, seed_ref[i], 1'b1, "sweep");
    end
    idle_op(1'b0, 10'd900, 24'h0, "ignored_wr_900");

    // Read-before-write on the same address.
    idle_op(1'b1, 10'd5, 24'hABCDEF, "rbw_old");
    idle_op(1'b0, 10'd5, 24'h0, "rbw_new");

    // Random traffic over a narrow window to force address collisions.
    for (int i = 0; i < 300; i++) begin
      idle_op(1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)), 24'($urandom), "rand_idle");
    end

    // Overwrite addr 10, abort restore at k=500, restart and recheck.
    idle_op(1'b1, 10'd10, 24'hFFFFFF, "wr10");
    idle_op(1'b0, 10'd10, 24'h0, "rd10_new");
    do_reset(2);
    run_restore(500, rise);
    check("no_ready_at_k500", 32'(rise), 32'd0);
    do_reset(3);
    run_restore(1100, rise);
    check("ready_rise_after_abort", 32'(rise), 32'd1024);
    idle_op(1'b0, 10'd10, 24'h0, "rd10_restored");
    for (int i = 0; i < 40; i++) begin
      idle_op(1'b0, 10'($urandom_range(0, DEPTH - 1)), 24'h0, "post_abort_rd");
    end

    // Drain the scoreboard, bounded.
    step(1'b0, 10'd0, 24'h0, 24'h0, 1'b0, "");
    repeat (3) @(negedge clk);
    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
